// File: rtl/frame_read_addr_gen_pkg.sv
// Shared memory map and FSM encoding for the DRAM frame buffer address
// generators. The write-side generator imports the same package, so both
// sides agree on where the buffers and the pointer mailbox live.
package frame_read_addr_gen_pkg;

  localparam logic [31:0] BUF0_ADDR       = 32'h0F80_0000;
  localparam logic [31:0] BUF_STRIDE      = 32'h0040_0000;
  localparam int          NUM_BUFS        = 4;
  localparam logic [31:0] MAILBOX_ADDR    = 32'h1900_0000;
  localparam int          BURST_BYTES     = 128;
  localparam int          BEATS_PER_BURST = 16;

  typedef enum logic [2:0] {
    IDLE,
    PTR_REQ,
    PTR_WAIT,
    STREAM,
    DONE
  } state_t;

  // True when ptr is exactly the base address of one of the NUM_BUFS buffers.
  function automatic logic is_buf_base(input logic [31:0] ptr,
                                       input logic [31:0] base0,
                                       input logic [31:0] stride);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_BUFS; k++) begin
      if (ptr == base0 + (32'(k) * stride)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/frame_read_addr_gen_read_burst_tracker.sv
// read_burst_tracker: follows the read data returning for issued bursts.
// Counts beats inside the current burst, keeps the number of bursts that
// have been issued but not fully returned, and forwards each beat with one
// register of latency.
//
// Ports:
//   sys_clk, sys_rst   clock, synchronous active-high reset
//   clear              zero the beat and outstanding counters (new frame)
//   issue              one burst address was accepted this cycle
//   beat_valid         a frame data beat is present on beat_data
//   beat_data          64-bit read beat
//   outstanding        bursts issued but not yet completed
//   data_out           registered copy of the last accepted beat
//   data_out_valid     data_out carries a beat this cycle
module read_burst_tracker
  import frame_read_addr_gen_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        clear,
  input  logic        issue,
  input  logic        beat_valid,
  input  logic [63:0] beat_data,
  output logic [3:0]  outstanding,
  output logic [63:0] data_out,
  output logic        data_out_valid
);

  logic [3:0]  beat_cnt_reg;
  logic [3:0]  outstanding_reg;
  logic [63:0] data_out_reg;
  logic        data_out_valid_reg;
  logic        burst_done;

  // The last beat of a burst retires it from the outstanding count.
  assign burst_done = beat_valid && (beat_cnt_reg == 4'(BEATS_PER_BURST - 1));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      beat_cnt_reg       <= '0;
      outstanding_reg    <= '0;
      data_out_reg       <= '0;
      data_out_valid_reg <= 1'b0;
    end else begin
      data_out_valid_reg <= beat_valid;
      if (beat_valid) data_out_reg <= beat_data;

      if (clear) begin
        beat_cnt_reg    <= '0;
        outstanding_reg <= '0;
      end else begin
        // 4-bit counter wraps naturally at 16 beats.
        if (beat_valid) beat_cnt_reg <= beat_cnt_reg + 4'd1;
        // Issue and completion in the same cycle cancel out.
        case ({issue, burst_done})
          2'b10:   outstanding_reg <= outstanding_reg + 4'd1;
          2'b01:   outstanding_reg <= outstanding_reg - 4'd1;
          default: outstanding_reg <= outstanding_reg;
        endcase
      end
    end
  end

  assign outstanding    = outstanding_reg;
  assign data_out       = data_out_reg;
  assign data_out_valid = data_out_valid_reg;

endmodule

// File: rtl/frame_read_addr_gen.sv
// frame_read_addr_gen: read-side DRAM frame address generator.
// On frame_start it reads the pointer mailbox burst, adopts the reported
// buffer base if it is a legal buffer address, then walks that buffer in
// BURST_BYTES read bursts and forwards the returned beats downstream.
//
// Ports:
//   sys_clk, sys_rst        clock, synchronous active-high reset
//   frame_start             pulse requesting a new frame read
//   space_avail             downstream can take one more full burst
//   addr/addr_valid/addr_ready  burst read address handshake
//   data_in/data_in_valid   returned read beats (no backpressure)
//   data_out/data_out_valid forwarded frame beats (latency 1)
//   busy                    not idle
//   frame_done              pulse the cycle after the last beat is forwarded
//   overrun                 pulse when frame_start is dropped because busy
module frame_read_addr_gen #(
  parameter int unsigned FRAME_BYTES     = 4147200,
  parameter int unsigned BURST_BYTES     = 128,
  parameter logic [31:0] MAILBOX_ADDR    = frame_read_addr_gen_pkg::MAILBOX_ADDR,
  parameter logic [31:0] BUF0_ADDR       = frame_read_addr_gen_pkg::BUF0_ADDR,
  parameter logic [31:0] BUF_STRIDE      = frame_read_addr_gen_pkg::BUF_STRIDE,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        frame_start,
  input  logic        space_avail,
  output logic [31:0] addr,
  output logic        addr_valid,
  input  logic        addr_ready,
  input  logic [63:0] data_in,
  input  logic        data_in_valid,
  output logic [63:0] data_out,
  output logic        data_out_valid,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  import frame_read_addr_gen_pkg::*;

  localparam int unsigned NUM_BURSTS = FRAME_BYTES / BURST_BYTES;
  localparam int          ISSUE_W    = $clog2(NUM_BURSTS) + 1;
  localparam logic [ISSUE_W-1:0] NUM_BURSTS_C = ISSUE_W'(NUM_BURSTS);
  localparam logic [3:0]         MAX_OUT_C    = 4'(MAX_OUTSTANDING);

  state_t              state_reg, state_next;
  logic [31:0]         cur_base_reg;
  logic [31:0]         offset_reg;
  logic [ISSUE_W-1:0]  issued_reg;
  logic [3:0]          mbox_cnt_reg;
  logic                hold_reg;
  logic                overrun_reg;

  logic [3:0]          outstanding;
  logic                issue_ok;
  logic                addr_fire;
  logic                stream_fire;

  assign addr_fire   = addr_valid && addr_ready;
  assign stream_fire = addr_fire && (state_reg == STREAM);

  always_comb begin
    state_next = state_reg;
    addr       = '0;
    addr_valid = 1'b0;
    frame_done = 1'b0;
    issue_ok   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (frame_start) state_next = PTR_REQ;
      end
      PTR_REQ: begin
        addr       = MAILBOX_ADDR;
        addr_valid = 1'b1;
        if (addr_ready) state_next = PTR_WAIT;
      end
      PTR_WAIT: begin
        if (data_in_valid && (mbox_cnt_reg == 4'(BEATS_PER_BURST - 1)))
          state_next = STREAM;
      end
      STREAM: begin
        issue_ok   = (issued_reg < NUM_BURSTS_C) && (outstanding < MAX_OUT_C) && space_avail;
        addr       = cur_base_reg + offset_reg;
        // hold_reg keeps an unaccepted request up even if space_avail drops.
        addr_valid = hold_reg || issue_ok;
        if ((issued_reg == NUM_BURSTS_C) && (outstanding == 4'd0))
          state_next = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg    <= IDLE;
      cur_base_reg <= BUF0_ADDR;
      offset_reg   <= '0;
      issued_reg   <= '0;
      mbox_cnt_reg <= '0;
      hold_reg     <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      overrun_reg <= frame_start && (state_reg != IDLE);
      hold_reg    <= (state_reg == STREAM) && addr_valid && !addr_ready;

      if (state_reg == PTR_WAIT) begin
        offset_reg <= '0;
        issued_reg <= '0;
        if (data_in_valid) begin
          // Counter wraps back to 0 after the 16th mailbox beat.
          mbox_cnt_reg <= mbox_cnt_reg + 4'd1;
          // Only beat 0 carries the pointer; an illegal pointer keeps the
          // previous buffer so a corrupt mailbox never sends reads astray.
          if ((mbox_cnt_reg == 4'd0) &&
              is_buf_base(data_in[31:0], BUF0_ADDR, BUF_STRIDE))
            cur_base_reg <= data_in[31:0];
        end
      end

      if (stream_fire) begin
        offset_reg <= offset_reg + 32'(BURST_BYTES);
        issued_reg <= issued_reg + 1'b1;
      end
    end
  end

  read_burst_tracker u_tracker (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .clear          (state_reg == PTR_WAIT),
    .issue          (stream_fire),
    .beat_valid     (data_in_valid && (state_reg == STREAM)),
    .beat_data      (data_in),
    .outstanding    (outstanding),
    .data_out       (data_out),
    .data_out_valid (data_out_valid)
  );

  assign busy    = (state_reg != IDLE);
  assign overrun = overrun_reg;

endmodule
